// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// stage payload widths, packed payload/control layouts and the bubble value.
package pipe_pkg;

   // EX/MEM payload: ALU result, store data and destination register
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  rd;
   } exmem_payload_t;

   // EX/MEM control bits carried alongside the payload
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
   } exmem_ctrl_t;

   // ID/EX payload: both source operands, immediate and register indices
   typedef struct packed {
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } idex_payload_t;

   // ID/EX control bits: execute-stage controls plus the EX/MEM set
   typedef struct packed {
      logic        alu_src;
      logic [1:0]  alu_op;
      logic        branch;
      exmem_ctrl_t later;
   } idex_ctrl_t;

   localparam int DATA_W_EXMEM = $bits(exmem_payload_t);
   localparam int CTRL_W_EXMEM = $bits(exmem_ctrl_t);
   localparam int DATA_W_IDEX  = $bits(idex_payload_t);
   localparam int CTRL_W_IDEX  = $bits(idex_ctrl_t);

   // Control value of a bubble: every control bit inactive
   localparam logic [63:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for performance statistics; it sticks at the
// all-ones value instead of wrapping so long stalls never read as short ones.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   // Count up on inc until all ones; reset and clear both return to zero
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two stages: valid/ready handshake, an
// optional skid entry that keeps in_ready_o free of out_ready_i, flush to
// bubble, a global start enable and a saturating backpressure counter.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_EXMEM,
   parameter int CTRL_W = CTRL_W_EXMEM,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              main_v, main_v_n;
   logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
   logic [DATA_W-1:0] main_data, main_data_n;
   logic              skid_v, skid_v_n;
   logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
   logic [DATA_W-1:0] skid_data, skid_data_n;
   logic              in_ready;
   logic              acc;
   logic              pop;
   logic              stall;

   // Ready: registered (skid occupancy only) with a skid entry, otherwise
   // a pass-through that lets a pop free the main entry in the same cycle
   always_comb begin
      in_ready = 1'b0;
      if (SKID != 0) begin
         in_ready = start_i & ~skid_v;
      end else begin
         in_ready = start_i & (~main_v | out_ready_i);
      end
   end

   assign acc         = in_valid_i & in_ready;
   assign pop         = main_v & out_ready_i & start_i;
   assign stall       = start_i & main_v & ~out_ready_i;
   assign in_ready_o  = in_ready;
   assign out_valid_o = main_v;
   assign out_ctrl_o  = main_v ? main_ctrl : CTRL_W'(CTRL_BUBBLE);
   assign out_data_o  = main_data;

   // Next entry contents: flush clears valids and control, otherwise pop
   // and accept are combined so the entries always drain in arrival order
   always_comb begin
      main_v_n    = main_v;
      main_ctrl_n = main_ctrl;
      main_data_n = main_data;
      skid_v_n    = skid_v;
      skid_ctrl_n = skid_ctrl;
      skid_data_n = skid_data;
      if (flush_i) begin
         main_v_n    = 1'b0;
         main_ctrl_n = CTRL_W'(CTRL_BUBBLE);
         skid_v_n    = 1'b0;
         skid_ctrl_n = CTRL_W'(CTRL_BUBBLE);
      end else if (start_i) begin
         if (skid_v && pop) begin
            main_ctrl_n = skid_ctrl;
            main_data_n = skid_data;
            skid_v_n    = 1'b0;
         end else if (acc && (!main_v || pop)) begin
            main_v_n    = 1'b1;
            main_ctrl_n = in_ctrl_i;
            main_data_n = in_data_i;
         end else if (acc && (SKID != 0)) begin
            skid_v_n    = 1'b1;
            skid_ctrl_n = in_ctrl_i;
            skid_data_n = in_data_i;
         end else if (pop) begin
            main_v_n = 1'b0;
         end
      end
   end

   // Entry registers with synchronous reset that overrides flush and start
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_v    <= 1'b0;
         main_ctrl <= '0;
         main_data <= '0;
         skid_v    <= 1'b0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         main_v    <= main_v_n;
         main_ctrl <= main_ctrl_n;
         main_data <= main_data_n;
         skid_v    <= skid_v_n;
         skid_ctrl <= skid_ctrl_n;
         skid_data <= skid_data_n;
      end
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (stall),
      .clr   (1'b0),
      .count (stall_cnt_o)
   );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid instance and a no-skid instance with a
// 3-bit counter share one stimulus stream and are compared every cycle with a
// FIFO-based reference model, plus table vectors and directed corner cases.
module tb_pipe_stage_elastic;
   import pipe_pkg::*;

   localparam int DW = DATA_W_EXMEM;
   localparam int CW = CTRL_W_EXMEM;

   logic          clk = 1'b0;
   logic          rst, start, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          s_in_ready, s_out_valid;
   logic [CW-1:0] s_out_ctrl;
   logic [DW-1:0] s_out_data;
   logic [15:0]   s_cnt;
   logic          n_in_ready, n_out_valid;
   logic [CW-1:0] n_out_ctrl;
   logic [DW-1:0] n_out_data;
   logic [2:0]    n_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_s (
      .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_ctrl_i(in_ctrl),
      .in_data_i(in_data), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
      .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data), .stall_cnt_o(s_cnt));

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(3)) dut_n (
      .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(n_in_ready), .in_ctrl_i(in_ctrl),
      .in_data_i(in_data), .out_valid_o(n_out_valid), .out_ready_i(out_ready),
      .out_ctrl_o(n_out_ctrl), .out_data_o(n_out_data), .stall_cnt_o(n_cnt));

   // Reference model: index 0 = no-skid (capacity 1, counter max 7),
   // index 1 = skid (capacity 2, counter max 65535)
   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        mq [2][2];
   int            msize [2];
   logic [DW-1:0] mhead [2];
   int            mcnt [2];
   int            mmax [2] = '{7, 65535};
   bit            model_live = 1'b0;

   function automatic logic model_in_ready(input int m);
      if (m == 1) return start && (msize[m] < 2);
      return start && ((msize[m] == 0) || out_ready);
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic ordy, input logic st, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      start     = st;
      flush     = fl;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Advance the model on each rising edge from the inputs it sees there
   always @(posedge clk) begin
      logic m_acc, m_pop;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            msize[m] = 0;
            mhead[m] = '0;
            mcnt[m]  = 0;
         end else begin
            m_acc = in_valid && model_in_ready(m);
            m_pop = (msize[m] > 0) && out_ready && start;
            if (start && (msize[m] > 0) && !out_ready && (mcnt[m] < mmax[m])) mcnt[m]++;
            if (flush) begin
               msize[m] = 0;
            end else if (start) begin
               if (m_pop) begin
                  mq[m][0] = mq[m][1];
                  msize[m]--;
               end
               if (m_acc) begin
                  mq[m][msize[m]] = {in_ctrl, in_data};
                  msize[m]++;
               end
               if (msize[m] > 0) mhead[m] = mq[m][0].data;
            end
         end
      end
      if (rst) model_live = 1'b1;
   end

   // Compare both instances against the model mid-cycle
   always @(negedge clk) begin
      if (model_live) begin
         check_output("s_valid", 128'(s_out_valid), 128'(msize[1] > 0));
         check_output("s_ctrl", 128'(s_out_ctrl), 128'((msize[1] > 0) ? mq[1][0].ctrl : '0));
         check_output("s_data", 128'(s_out_data), 128'((msize[1] > 0) ? mq[1][0].data : mhead[1]));
         check_output("s_ready", 128'(s_in_ready), 128'(model_in_ready(1)));
         check_output("s_cnt", 128'(s_cnt), 128'(mcnt[1]));
         check_output("n_valid", 128'(n_out_valid), 128'(msize[0] > 0));
         check_output("n_ctrl", 128'(n_out_ctrl), 128'((msize[0] > 0) ? mq[0][0].ctrl : '0));
         check_output("n_data", 128'(n_out_data), 128'((msize[0] > 0) ? mq[0][0].data : mhead[0]));
         check_output("n_ready", 128'(n_in_ready), 128'(model_in_ready(0)));
         check_output("n_cnt", 128'(n_cnt), 128'(mcnt[0]));
      end
   end

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic [CW-1:0] exp_ctrl;
      logic          exp_ready;
   } vec_t;

   vec_t vecs [10];

   initial begin
      // Streaming vectors: data 1..8 in, each visible one cycle later
      for (int i = 0; i < 10; i++) begin
         vecs[i].valid     = (i < 8);
         vecs[i].data      = DW'(i + 1);
         vecs[i].ctrl      = 4'b1010;
         vecs[i].exp_valid = (i >= 1) && (i <= 8);
         vecs[i].exp_data  = (i == 9) ? DW'(8) : DW'(i);
         vecs[i].exp_ctrl  = vecs[i].exp_valid ? 4'b1010 : 4'b0000;
         vecs[i].exp_ready = 1'b1;
      end

      rst = 1'b1;
      apply_stimulus(1'b1, DW'(69'h1_2345_6789_ABCD_EF01), 4'hF, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_output("rst_valid", 128'(s_out_valid), 128'(0));
      check_output("rst_ctrl", 128'(s_out_ctrl), 128'(0));
      check_output("rst_data", 128'(s_out_data), 128'(0));
      check_output("rst_cnt", 128'(s_cnt), 128'(0));
      check_output("rst_n_data", 128'(n_out_data), 128'(0));
      rst = 1'b0;
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_output("rel_ready", 128'(s_in_ready), 128'(1));
      next_cycle();

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].valid, vecs[i].data, vecs[i].ctrl, 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         check_output("vec_valid", 128'(s_out_valid), 128'(vecs[i].exp_valid));
         check_output("vec_data", 128'(s_out_data), 128'(vecs[i].exp_data));
         check_output("vec_ctrl", 128'(s_out_ctrl), 128'(vecs[i].exp_ctrl));
         check_output("vec_ready", 128'(s_in_ready), 128'(vecs[i].exp_ready));
         check_output("vec_n_data", 128'(n_out_data), 128'(vecs[i].exp_data));
         check_output("vec_n_ready", 128'(n_in_ready), 128'(vecs[i].exp_ready));
         next_cycle();
      end

      // Backpressure: A into main, B into skid, third entry refused
      apply_stimulus(1'b1, DW'('h111), 4'h3, 1'b0, 1'b1, 1'b0);
      @(negedge clk); check_output("bp_a_valid", 128'(s_out_valid), 128'(0)); next_cycle();
      apply_stimulus(1'b1, DW'('h222), 4'h5, 1'b0, 1'b1, 1'b0);
      @(negedge clk); check_output("bp_b_data", 128'(s_out_data), 128'('h111)); next_cycle();
      apply_stimulus(1'b1, DW'('h333), 4'h7, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check_output("bp_full_ready", 128'(s_in_ready), 128'(0));
      check_output("bp_cnt1", 128'(s_cnt), 128'(1));
      next_cycle();
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); check_output("bp_cnt2", 128'(s_cnt), 128'(2)); next_cycle();
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_output("drain_a", 128'(s_out_data), 128'('h111));
      check_output("drain_cnt", 128'(s_cnt), 128'(3));
      next_cycle();
      @(negedge clk);
      check_output("drain_b", 128'(s_out_data), 128'('h222));
      check_output("drain_b_ctrl", 128'(s_out_ctrl), 128'(5));
      check_output("drain_ready", 128'(s_in_ready), 128'(1));
      next_cycle();

      // Flush with both entries full and an offered entry C
      apply_stimulus(1'b1, DW'('h444), 4'h1, 1'b0, 1'b1, 1'b0);
      @(negedge clk); check_output("fl_empty_ctrl", 128'(s_out_ctrl), 128'(0)); next_cycle();
      apply_stimulus(1'b1, DW'('h555), 4'h2, 1'b0, 1'b1, 1'b0);
      next_cycle();
      apply_stimulus(1'b1, DW'('hCCC), 4'hF, 1'b0, 1'b1, 1'b1);
      @(negedge clk); check_output("fl_cnt", 128'(s_cnt), 128'(4)); next_cycle();
      apply_stimulus(1'b1, DW'('h666), 4'hE, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check_output("fl_valid", 128'(s_out_valid), 128'(0));
      check_output("fl_ctrl", 128'(s_out_ctrl), 128'(0));
      check_output("fl_hold_data", 128'(s_out_data), 128'('h444));
      next_cycle();
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_output("fl_drop_valid", 128'(s_out_valid), 128'(0));
      check_output("fl_drop_cnt", 128'(s_cnt), 128'(5));
      next_cycle();

      // Flush while start is low still clears the entries
      apply_stimulus(1'b1, DW'('h777), 4'h3, 1'b0, 1'b1, 1'b0); next_cycle();
      apply_stimulus(1'b1, DW'('h888), 4'h4, 1'b0, 1'b1, 1'b0); next_cycle();
      apply_stimulus(1'b1, DW'('h999), 4'h6, 1'b0, 1'b0, 1'b1);
      @(negedge clk); check_output("fls_ready", 128'(s_in_ready), 128'(0)); next_cycle();
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_output("fls_valid", 128'(s_out_valid), 128'(0));
      check_output("fls_cnt", 128'(s_cnt), 128'(6));
      next_cycle();

      // Start low for five cycles: nothing accepted or consumed
      apply_stimulus(1'b1, DW'('hAAA), 4'h1, 1'b1, 1'b1, 1'b0); next_cycle();
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, DW'('hBBB), 4'h2, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         check_output("hold_ready", 128'(s_in_ready), 128'(0));
         check_output("hold_n_ready", 128'(n_in_ready), 128'(0));
         check_output("hold_data", 128'(s_out_data), 128'('hAAA));
         check_output("hold_cnt", 128'(s_cnt), 128'(6));
         next_cycle();
      end
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk); check_output("hold_after", 128'(s_out_data), 128'('hAAA)); next_cycle();

      // Counter saturation on the 3-bit instance
      apply_stimulus(1'b1, DW'('hDDD), 4'h1, 1'b0, 1'b1, 1'b0); next_cycle();
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      repeat (10) next_cycle();
      @(negedge clk);
      check_output("sat_n_cnt", 128'(n_cnt), 128'(7));
      check_output("sat_s_cnt", 128'(s_cnt), 128'(16));
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      next_cycle();
      next_cycle();

      // Randomised traffic checked by the model every cycle
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         apply_stimulus($urandom_range(0, 3) != 0, DW'({$urandom, $urandom, $urandom}),
                        CW'($urandom), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
         next_cycle();
      end
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed inter-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic data payload plus control bits between two pipeline stages using a valid/ready handshake, an optional skid entry, flush-to-bubble, and a global start enable. It also counts backpressure cycles so performance tests can report stage stalls.

Parameters:
DATA_W, 69, payload width in bits (for example ALU result 32 + store data 32 + rd address 5).
CTRL_W, 4, control-bit width (for example RegWrite, MemtoReg, MemRead, MemWrite). Forced to 0 in bubbles.
SKID, 1, 1 = two-entry skid buffer with registered ready; 0 = single entry with combinational ready.
CNT_W, 16, width of the stall counter.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  global enable; when 0, all state holds and nothing is accepted or consumed.
flush_i  in  1  discard all held entries; has priority over all other events.
in_valid_i  in  1  upstream stage presents an entry.
in_ready_o  out  1  stage can accept an entry this cycle.
in_ctrl_i  in  CTRL_W  upstream control bits.
in_data_i  in  DATA_W  upstream payload.
out_valid_o  out  1  an entry is presented downstream.
out_ready_i  in  1  downstream stage accepts the entry this cycle.
out_ctrl_o  out  CTRL_W  control bits; all 0 whenever out_valid_o = 0.
out_data_o  out  DATA_W  payload; holds its last value when out_valid_o = 0.
stall_cnt_o  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Events (evaluated at each rising edge):
  - acc = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i & start_i.
- Reset (rst_i = 1): main_v = 0, skid_v = 0, all ctrl/data registers = 0, stall_cnt_o = 0. Reset overrides flush_i and start_i.
- Storage: main entry (M) drives the outputs; skid entry (S) exists only when SKID = 1.
- out_valid_o = main_v; out_ctrl_o = main_v ? M.ctrl : 0; out_data_o = M.data.
- in_ready_o:
  - SKID = 1: start_i & ~skid_v. No combinational path from out_ready_i.
  - SKID = 0: start_i & (~main_v | out_ready_i).
- start_i = 0: M, S, and stall_cnt_o all hold. in_ready_o = 0 and pop = 0.
- flush_i = 1 (with start_i = 1 or 0):
  - main_v = skid_v = 0 next cycle; M.ctrl and S.ctrl = 0; data registers hold.
  - A same-cycle acc is dropped (flush wins).
  - stall_cnt_o still updates per its own rule.
- Normal update (SKID = 1, start_i = 1, no flush):
  - ~main_v & acc: load M; latency from input to output is 1 cycle.
  - main_v & pop & ~acc & ~skid_v: main_v = 0.
  - main_v & pop & acc: load M from the input; main_v stays 1.
  - main_v & ~pop & acc: load S; skid_v = 1 (in_ready_o drops next cycle).
  - skid_v & pop: M takes S, skid_v = 0 (acc is impossible here since in_ready_o = 0).
  - Otherwise: hold.
- Normal update (SKID = 0): the same rules minus every S path; acc with a pop loads M in the same cycle.
- Ordering: strict FIFO. No entry is ever duplicated or lost except by flush or reset.
- Stall counter: increments when start_i & main_v & ~out_ready_i; saturates at 2^CNT_W - 1 (no wrap). Cleared only by rst_i.
- Hold stability: while out_valid_o = 1 and no pop occurs, out_ctrl_o and out_data_o must not change.

Decomposition:
- Shared package pipe_pkg holds:
  - Widths: DATA_W_EXMEM = 69, CTRL_W_EXMEM = 4, DATA_W_IDEX, CTRL_W_IDEX.
  - Constant CTRL_BUBBLE = '0.
  - A packed struct typedef per stage payload, so each instantiation casts its struct to and from data_i/data_o.
- One sub-module, pipe_sat_counter (CNT_W parameter, inc/clr inputs, saturating). It is reused by other performance counters.
- The entry storage stays inline in this block.

Test Plan:
- Reset: hold rst_i = 1 for 2 cycles with in_valid_i = 1 -> out_valid_o = 0, out_ctrl_o = 0, out_data_o = 0, stall_cnt_o = 0; with SKID = 1, in_ready_o = 1 the cycle after release.
- Streaming: SKID = 1, out_ready_i = 1, present data 1..8 with ctrl 4'b1010 on consecutive cycles -> out_data_o = 1..8 each 1 cycle later, no gaps, in_ready_o stays 1.
- Backpressure:
  - Present A then B while out_ready_i = 0 -> M = A, S = B, in_ready_o = 0, stall_cnt_o increments every cycle.
  - Raise out_ready_i for 2 cycles -> A then B are emitted; in_ready_o returns to 1.
- Flush:
  - With M and S full, assert flush_i together with in_valid_i (data C) -> next cycle out_valid_o = 0, out_ctrl_o = 0, C never appears.
  - Same flush with start_i = 0 -> the entries are still cleared.
- start_i = 0 for 5 cycles with in_valid_i = 1 and out_ready_i = 1 -> no acceptance, no output change, stall_cnt_o constant.
- Saturation and mode check:
  - CNT_W = 3 with 10 stalled cycles -> stall_cnt_o = 7.
  - SKID = 0: out_valid_o = 1, out_ready_i = 1, in_valid_i = 1 -> in_ready_o = 1 and the new entry lands in the same cycle.
